// File: rtl/ar_arbiter_pkg.sv
// Shared types and constants for the two-master AXI read-address arbiter.
// Bus widths live here so every file of the arbiter agrees on them.
package ar_arbiter_pkg;

  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;
  localparam int AXI_SIZE_BITS = 3;
  localparam int AXI_DATA_BITS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [3:0] TAG_M0 = 4'b0001;
  localparam logic [3:0] TAG_M1 = 4'b0010;

  typedef logic grant_t;
  localparam grant_t GRANT_M0 = 1'b0;
  localparam grant_t GRANT_M1 = 1'b1;

  // Master tag placed above the master's own ID on the downstream ARID.
  function automatic logic [3:0] masterTag(input grant_t g);
    return (g == GRANT_M1) ? TAG_M1 : TAG_M0;
  endfunction

endpackage

// File: rtl/ar_arbiter_rr_pick.sv
// Two-requester winner select. Round-robin by default; defining
// AR_ARBITER_FIXED_PRIO_EN makes M0 always win and drops the pointer.
module rr_pick
  import ar_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_req0,
  input  logic   i_req1,
  input  logic   i_take,
  output logic   o_valid,
  output grant_t o_winner
);

  assign o_valid = i_req0 | i_req1;

`ifdef AR_ARBITER_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = ^{clk, rst, i_take};
  assign o_winner = i_req0 ? GRANT_M0 : GRANT_M1;
`else
  grant_t r_ptr;

  // Pointer hands priority to the master that did not just win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_ptr <= GRANT_M0;
    else if (i_take && o_valid)
      r_ptr <= ~o_winner;
  end

  assign o_winner = (i_req0 && i_req1) ? r_ptr :
                    (i_req0 ? GRANT_M0 : GRANT_M1);
`endif

endmodule

// File: rtl/ar_arbiter.sv
// Two-master AXI read arbiter: one burst in flight, AR forwarded from
// registered payload, R routed to the granted master until RLAST.
// Winner policy set by AR_ARBITER_FIXED_PRIO_EN (see rr_pick).
module ar_arbiter
  import ar_arbiter_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AXI_ID_BITS-1:0]   ARID_M0,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR_M0,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN_M0,
  input  logic [AXI_SIZE_BITS-1:0] ARSIZE_M0,
  input  logic [1:0]               ARBURST_M0,
  input  logic                     ARVALID_M0,
  output logic                     ARREADY_M0,
  input  logic [AXI_ID_BITS-1:0]   ARID_M1,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR_M1,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN_M1,
  input  logic [AXI_SIZE_BITS-1:0] ARSIZE_M1,
  input  logic [1:0]               ARBURST_M1,
  input  logic                     ARVALID_M1,
  output logic                     ARREADY_M1,
  output logic [AXI_ID_BITS-1:0]   RID_M0,
  output logic [AXI_DATA_BITS-1:0] RDATA_M0,
  output logic [1:0]               RRESP_M0,
  output logic                     RLAST_M0,
  output logic                     RVALID_M0,
  input  logic                     RREADY_M0,
  output logic [AXI_ID_BITS-1:0]   RID_M1,
  output logic [AXI_DATA_BITS-1:0] RDATA_M1,
  output logic [1:0]               RRESP_M1,
  output logic                     RLAST_M1,
  output logic                     RVALID_M1,
  input  logic                     RREADY_M1,
  output logic [AXI_IDS_BITS-1:0]  ARID_S,
  output logic [AXI_ADDR_BITS-1:0] ARADDR_S,
  output logic [AXI_LEN_BITS-1:0]  ARLEN_S,
  output logic [AXI_SIZE_BITS-1:0] ARSIZE_S,
  output logic [1:0]               ARBURST_S,
  output logic                     ARVALID_S,
  input  logic                     ARREADY_S,
  input  logic [AXI_IDS_BITS-1:0]  RID_S,
  input  logic [AXI_DATA_BITS-1:0] RDATA_S,
  input  logic [1:0]               RRESP_S,
  input  logic                     RLAST_S,
  input  logic                     RVALID_S,
  output logic                     RREADY_S
);

  state_t                   r_state;
  state_t                   w_next;
  grant_t                   r_grant;
  logic [AXI_IDS_BITS-1:0]  r_arid;
  logic [AXI_ADDR_BITS-1:0] r_araddr;
  logic [AXI_LEN_BITS-1:0]  r_arlen;
  logic [AXI_SIZE_BITS-1:0] r_arsize;
  logic [1:0]               r_arburst;
  logic                     w_pick_valid;
  grant_t                   w_pick_winner;
  logic                     w_take;
  logic                     w_unused;

  assign w_take   = (r_state == IDLE) && w_pick_valid;
  assign w_unused = ^RID_S[AXI_IDS_BITS-1:AXI_ID_BITS];

  rr_pick u_pick (
    .clk      (clk),
    .rst      (rst),
    .i_req0   (ARVALID_M0),
    .i_req1   (ARVALID_M1),
    .i_take   (w_take),
    .o_valid  (w_pick_valid),
    .o_winner (w_pick_winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Payload is captured with the master tag already applied, so a fresh
  // reset leaves the whole downstream AR bus at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant   <= GRANT_M0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
    end else if (w_take) begin
      r_grant <= w_pick_winner;
      if (w_pick_winner == GRANT_M1) begin
        r_arid    <= {masterTag(GRANT_M1), ARID_M1};
        r_araddr  <= ARADDR_M1;
        r_arlen   <= ARLEN_M1;
        r_arsize  <= ARSIZE_M1;
        r_arburst <= ARBURST_M1;
      end else begin
        r_arid    <= {masterTag(GRANT_M0), ARID_M0};
        r_araddr  <= ARADDR_M0;
        r_arlen   <= ARLEN_M0;
        r_arsize  <= ARSIZE_M0;
        r_arburst <= ARBURST_M0;
      end
    end
  end

  assign ARID_S    = r_arid;
  assign ARADDR_S  = r_araddr;
  assign ARLEN_S   = r_arlen;
  assign ARSIZE_S  = r_arsize;
  assign ARBURST_S = r_arburst;

  always_comb begin
    w_next     = r_state;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    ARVALID_S  = 1'b0;
    RREADY_S   = 1'b0;
    RID_M0     = '0;
    RDATA_M0   = '0;
    RRESP_M0   = '0;
    RLAST_M0   = 1'b0;
    RVALID_M0  = 1'b0;
    RID_M1     = '0;
    RDATA_M1   = '0;
    RRESP_M1   = '0;
    RLAST_M1   = 1'b0;
    RVALID_M1  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          ARREADY_M0 = (w_pick_winner == GRANT_M0);
          ARREADY_M1 = (w_pick_winner == GRANT_M1);
          w_next     = ADDR;
        end
      end
      ADDR: begin
        ARVALID_S = 1'b1;
        if (ARREADY_S)
          w_next = DATA;
      end
      DATA: begin
        if (r_grant == GRANT_M1) begin
          RVALID_M1 = RVALID_S;
          RID_M1    = RID_S[AXI_ID_BITS-1:0];
          RDATA_M1  = RDATA_S;
          RRESP_M1  = RRESP_S;
          RLAST_M1  = RLAST_S;
          RREADY_S  = RREADY_M1;
        end else begin
          RVALID_M0 = RVALID_S;
          RID_M0    = RID_S[AXI_ID_BITS-1:0];
          RDATA_M0  = RDATA_S;
          RRESP_M0  = RRESP_S;
          RLAST_M0  = RLAST_S;
          RREADY_S  = RREADY_M0;
        end
        if (RVALID_S && RREADY_S && RLAST_S)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ar_arbiter.sv
// Self-checking bench for ar_arbiter: vector table, hand-written corner
// sequences and random bursts checked against a grant-order model.
module tb_ar_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  ARID_M0 = '0, ARID_M1 = '0;
  logic [31:0] ARADDR_M0 = '0, ARADDR_M1 = '0;
  logic [3:0]  ARLEN_M0 = '0, ARLEN_M1 = '0;
  logic [2:0]  ARSIZE_M0 = '0, ARSIZE_M1 = '0;
  logic [1:0]  ARBURST_M0 = '0, ARBURST_M1 = '0;
  logic        ARVALID_M0 = 1'b0, ARVALID_M1 = 1'b0;
  logic        ARREADY_M0, ARREADY_M1;
  logic [3:0]  RID_M0, RID_M1;
  logic [31:0] RDATA_M0, RDATA_M1;
  logic [1:0]  RRESP_M0, RRESP_M1;
  logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1;
  logic        RREADY_M0 = 1'b0, RREADY_M1 = 1'b0;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic        ARVALID_S;
  logic        ARREADY_S = 1'b0;
  logic [7:0]  RID_S = '0;
  logic [31:0] RDATA_S = '0;
  logic [1:0]  RRESP_S = '0;
  logic        RLAST_S = 1'b0, RVALID_S = 1'b0;
  logic        RREADY_S;

  int   nChecks = 0;
  int   nFail = 0;
  logic mPtr = 1'b0;

  typedef struct {
    logic [1:0]  mask;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic        expWin;
    logic [7:0]  expArid;
  } vec_t;

  always #5 clk = ~clk;

  ar_arbiter dut (
    .clk(clk), .rst(rst),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0),
    .ARSIZE_M0(ARSIZE_M0), .ARBURST_M0(ARBURST_M0),
    .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1),
    .ARSIZE_M1(ARSIZE_M1), .ARBURST_M1(ARBURST_M1),
    .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0),
    .RLAST_M0(RLAST_M0), .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1),
    .RLAST_M1(RLAST_M1), .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
    .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
    .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Grant rule: a lone requester wins; on contention the priority holder wins.
  function automatic logic modelPick(input logic [1:0] mask);
    if (mask == 2'b01) return 1'b0;
    if (mask == 2'b10) return 1'b1;
`ifdef AR_ARBITER_FIXED_PRIO_EN
    return 1'b0;
`else
    return mPtr;
`endif
  endfunction

  function automatic logic anyOut();
    return |{ARREADY_M0, ARREADY_M1, ARVALID_S, RREADY_S, RVALID_M0, RVALID_M1,
             ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
             RID_M0, RDATA_M0, RRESP_M0, RLAST_M0,
             RID_M1, RDATA_M1, RRESP_M1, RLAST_M1};
  endfunction

  // One full burst starting from IDLE at a falling edge. gapBeat drops the
  // winner's RREADY for one cycle on that beat; abortBeat resets on that beat.
  task automatic applyStimulus(input logic [1:0] mask, input logic [3:0] id0, input logic [3:0] id1,
                               input logic [31:0] addr0, input logic [31:0] addr1,
                               input logic [3:0] len, input logic expWin, input logic [7:0] expArid,
                               input int stall, input int gapBeat, input int abortBeat);
    logic [31:0] expAddr;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        isLast;
    expAddr = expWin ? addr1 : addr0;
    ARID_M0 = id0; ARADDR_M0 = addr0; ARLEN_M0 = len; ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'b01;
    ARID_M1 = id1; ARADDR_M1 = addr1; ARLEN_M1 = len; ARSIZE_M1 = 3'd1; ARBURST_M1 = 2'b10;
    ARVALID_M0 = mask[0];
    ARVALID_M1 = mask[1];
    #1;
    checkOutput("arreadyGrant", 64'({ARREADY_M1, ARREADY_M0}), 64'(expWin ? 2'b10 : 2'b01));
    mPtr = ~expWin;
    @(negedge clk);
    if (expWin) ARVALID_M1 = 1'b0; else ARVALID_M0 = 1'b0;
    checkOutput("arvalidS", 64'(ARVALID_S), 64'(1));
    checkOutput("aridS", 64'(ARID_S), 64'(expArid));
    checkOutput("araddrS", 64'(ARADDR_S), 64'(expAddr));
    checkOutput("arlenS", 64'(ARLEN_S), 64'(len));
    checkOutput("arsizeBurstS", 64'({ARSIZE_S, ARBURST_S}), 64'(expWin ? 5'b001_10 : 5'b010_01));
    checkOutput("arreadyInAddr", 64'({ARREADY_M1, ARREADY_M0}), 64'(0));
    RVALID_S = 1'b1;
    RLAST_S  = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checkOutput("stallHold", 64'({ARVALID_S, ARID_S, ARADDR_S}), 64'({1'b1, expArid, expAddr}));
      checkOutput("stallQuiet", 64'({ARREADY_M1, ARREADY_M0, RREADY_S, RVALID_M1, RVALID_M0}), 64'(0));
    end
    RVALID_S  = 1'b0;
    RLAST_S   = 1'b0;
    ARREADY_S = 1'b1;
    @(negedge clk);
    ARREADY_S = 1'b0;
    RREADY_M0 = 1'b1;
    RREADY_M1 = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      data   = $urandom;
      resp   = 2'($urandom_range(0, 3));
      isLast = (b == int'(len));
      RVALID_S = 1'b1; RDATA_S = data; RRESP_S = resp; RLAST_S = isLast; RID_S = expArid;
      if (b == abortBeat) begin
        rst = 1'b0;
        #1;
        checkOutput("abortZero", 64'(anyOut()), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        mPtr = 1'b0;
        RVALID_S = 1'b0; RLAST_S = 1'b0; ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;
        #1;
        checkOutput("postAbortQuiet", 64'(anyOut()), 64'(0));
        return;
      end
      if (b == gapBeat) begin
        if (expWin) RREADY_M1 = 1'b0; else RREADY_M0 = 1'b0;
        #1;
        checkOutput("gapRreadyS", 64'(RREADY_S), 64'(0));
        @(negedge clk);
        checkOutput("gapBeatHeld", 64'(expWin ? RVALID_M1 : RVALID_M0), 64'(1));
        RREADY_M0 = 1'b1;
        RREADY_M1 = 1'b1;
      end
      #1;
      if (expWin) begin
        checkOutput("beatM1", {22'd0, RVALID_M1, RVALID_M0, RREADY_S, RLAST_M1, RRESP_M1, RID_M1, RDATA_M1},
                    {22'd0, 1'b1, 1'b0, 1'b1, isLast, resp, expArid[3:0], data});
        checkOutput("otherM0Zero", 64'(|{RDATA_M0, RRESP_M0, RLAST_M0, RID_M0}), 64'(0));
      end else begin
        checkOutput("beatM0", {22'd0, RVALID_M0, RVALID_M1, RREADY_S, RLAST_M0, RRESP_M0, RID_M0, RDATA_M0},
                    {22'd0, 1'b1, 1'b0, 1'b1, isLast, resp, expArid[3:0], data});
        checkOutput("otherM1Zero", 64'(|{RDATA_M1, RRESP_M1, RLAST_M1, RID_M1}), 64'(0));
      end
      @(negedge clk);
    end
    RVALID_S = 1'b0;
    RLAST_S  = 1'b0;
    #1;
    checkOutput("backToIdle", 64'({ARVALID_S, RREADY_S, RVALID_M1, RVALID_M0}), 64'(0));
  endtask

  initial begin
    vec_t        tbl[4];
    logic [3:0]  seq;
    logic [1:0]  mask;
    logic [3:0]  id0, id1, len;
    logic        w;
    int          stall, gap;

    tbl[0] = '{2'b01, 4'h3, 32'h0000_1000, 4'd0, 1'b0, 8'h13};
    tbl[1] = '{2'b10, 4'hA, 32'h2000_0040, 4'd1, 1'b1, 8'h2A};
    tbl[2] = '{2'b01, 4'hF, 32'hFFFF_FFFC, 4'd2, 1'b0, 8'h1F};
    tbl[3] = '{2'b10, 4'h0, 32'h0000_0000, 4'd0, 1'b1, 8'h20};

    @(negedge clk);
    checkOutput("resetZero", 64'(anyOut()), 64'(0));
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("idleZero", 64'(anyOut()), 64'(0));
    end

    for (int i = 0; i < 4; i++)
      applyStimulus(tbl[i].mask, tbl[i].id, tbl[i].id, tbl[i].addr, tbl[i].addr,
                    tbl[i].len, tbl[i].expWin, tbl[i].expArid, i, -1, -1);

`ifdef AR_ARBITER_FIXED_PRIO_EN
    seq = 4'b0000;
`else
    seq = 4'b1010;
`endif
    for (int i = 0; i < 4; i++)
      applyStimulus(2'b11, 4'h5, 4'h6, 32'h0000_4000, 32'h0000_8000, 4'd3, seq[i],
                    seq[i] ? 8'h26 : 8'h15, 0, -1, -1);
    mPtr = 1'b0;

    applyStimulus(2'b01, 4'h7, 4'h0, 32'h0000_0100, 32'h0, 4'd1, 1'b0, 8'h17, 5, -1, -1);
    applyStimulus(2'b10, 4'h0, 4'h9, 32'h0, 32'h0000_0200, 4'd3, 1'b1, 8'h29, 0, 1, -1);
    applyStimulus(2'b10, 4'h0, 4'hC, 32'h0, 32'h0000_0300, 4'd3, 1'b1, 8'h2C, 0, -1, 2);
    applyStimulus(2'b10, 4'h0, 4'hB, 32'h0, 32'h0000_0400, 4'd0, 1'b1, 8'h2B, 0, -1, -1);
    applyStimulus(2'b11, 4'h1, 4'h2, 32'h0000_0500, 32'h0000_0600, 4'd0, 1'b0, 8'h11, 0, -1, -1);

    for (int i = 0; i < 150; i++) begin
      mask  = 2'($urandom_range(1, 3));
      id0   = 4'($urandom);
      id1   = 4'($urandom);
      len   = 4'($urandom_range(0, 3));
      w     = modelPick(mask);
      stall = int'($urandom_range(0, 3));
      gap   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(len))) : -1;
      applyStimulus(mask, id0, id1, $urandom, $urandom, len, w,
                    {(w ? 4'h2 : 4'h1), (w ? id1 : id0)}, stall, gap, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
